// File: rtl/writeback_regfile_pkg.sv
// Shared constants and types for the Y86-64 writeback stage.
// Consumed by writeback_regfile and wb_regarray.
package writeback_regfile_pkg;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_NOP  = 4'h1;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] RSP      = 4'h4;

  typedef enum logic {
    RUN     = 1'b0,
    STOPPED = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_regarray.sv
// Program register array: two write ports (M over E), two comb reads.
// WB_READ_BYPASS_EN adds write-through from the write ports to the reads.
module wb_regarray
  import writeback_regfile_pkg::*;
#(
  parameter int NREG   = 15,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_we_e,
  input  logic [3:0]        i_dst_e,
  input  logic [DATA_W-1:0] i_val_e,
  input  logic              i_we_m,
  input  logic [3:0]        i_dst_m,
  input  logic [DATA_W-1:0] i_val_m,
  input  logic [3:0]        i_ra,
  input  logic [3:0]        i_rb,
  output logic [DATA_W-1:0] o_rva,
  output logic [DATA_W-1:0] o_rvb
);

  logic [DATA_W-1:0] r_regs [NREG];
  logic [DATA_W-1:0] w_ara;
  logic [DATA_W-1:0] w_arb;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (i_we_m && i_dst_m == 4'(i))
          r_regs[i] <= i_val_m;
        else if (i_we_e && i_dst_e == 4'(i))
          r_regs[i] <= i_val_e;
      end
    end
  end

  // ID 15 (RNONE) is not backed by storage and reads as zero
  always_comb begin
    w_ara = '0;
    w_arb = '0;
    if (i_ra < 4'(NREG))
      w_ara = r_regs[i_ra];
    if (i_rb < 4'(NREG))
      w_arb = r_regs[i_rb];
  end

`ifdef WB_READ_BYPASS_EN
  always_comb begin
    o_rva = w_ara;
    o_rvb = w_arb;
    if (i_we_m && i_dst_m == i_ra)
      o_rva = i_val_m;
    else if (i_we_e && i_dst_e == i_ra)
      o_rva = i_val_e;
    if (i_we_m && i_dst_m == i_rb)
      o_rvb = i_val_m;
    else if (i_we_e && i_dst_e == i_rb)
      o_rvb = i_val_e;
  end
`else
  assign o_rva = w_ara;
  assign o_rvb = w_arb;
`endif

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 writeback stage: register commit, status FSM, retire counter.
// Optional macro WB_READ_BYPASS_EN enables read write-through.
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int NREG   = 15,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        W_status,
  input  logic [3:0]        W_icode,
  input  logic [3:0]        W_dste,
  input  logic [3:0]        W_dstm,
  input  logic [DATA_W-1:0] W_vale,
  input  logic [DATA_W-1:0] W_valm,
  input  logic [3:0]        d_srca,
  input  logic [3:0]        d_srcb,
  output logic [DATA_W-1:0] d_rvala,
  output logic [DATA_W-1:0] d_rvalb,
  output logic [1:0]        stat,
  output logic              halted,
  output logic [CNT_W-1:0]  retired_count
);

  wb_state_t        r_state;
  wb_state_t        w_next;
  logic [1:0]       r_stat;
  logic [CNT_W-1:0] r_count;
  logic             w_commit;

  assign w_commit = (r_state == RUN) && (W_status == STAT_AOK);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RUN:     if (W_status != STAT_AOK) w_next = STOPPED;
      STOPPED: w_next = STOPPED;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_stat  <= STAT_AOK;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == RUN && W_status != STAT_AOK)
        r_stat <= W_status;
      // bubbles retire nothing; faulting/halting instrs never commit
      if (w_commit && W_icode != I_NOP)
        r_count <= r_count + CNT_W'(1);
    end
  end

  assign stat          = (r_state == STOPPED) ? r_stat : W_status;
  assign halted        = (r_state == STOPPED);
  assign retired_count = r_count;

  wb_regarray #(
    .NREG   (NREG),
    .DATA_W (DATA_W)
  ) u_regs (
    .clock   (clock),
    .reset   (reset),
    .i_we_e  (w_commit && W_dste != REG_NONE),
    .i_dst_e (W_dste),
    .i_val_e (W_vale),
    .i_we_m  (w_commit && W_dstm != REG_NONE),
    .i_dst_m (W_dstm),
    .i_val_m (W_valm),
    .i_ra    (d_srca),
    .i_rb    (d_srcb),
    .o_rva   (d_rvala),
    .o_rvb   (d_rvalb)
  );

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: vector table, hand
// sequences and a random run against a behavioural model.
module tb_writeback_regfile;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  W_status;
  logic [3:0]  W_icode, W_dste, W_dstm;
  logic [63:0] W_vale, W_valm;
  logic [3:0]  d_srca, d_srcb;
  logic [63:0] d_rvala, d_rvalb;
  logic [1:0]  stat;
  logic        halted;
  logic [31:0] retired_count;

  int total = 0;
  int bad   = 0;

  writeback_regfile dut (
    .clock(clock), .reset(reset),
    .W_status(W_status), .W_icode(W_icode),
    .W_dste(W_dste), .W_dstm(W_dstm),
    .W_vale(W_vale), .W_valm(W_valm),
    .d_srca(d_srca), .d_srcb(d_srcb),
    .d_rvala(d_rvala), .d_rvalb(d_rvalb),
    .stat(stat), .halted(halted),
    .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  // behavioural model of architectural state
  logic [63:0] m_regs [15];
  bit          m_stop;
  logic [1:0]  m_lstat;
  logic [31:0] m_cnt;

  function automatic void m_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = '0;
    m_stop = 0; m_lstat = 2'd0; m_cnt = '0;
  endfunction

  function automatic logic [63:0] m_rd(input logic [3:0] a);
    if (a == 4'hF) return 64'd0;
`ifdef WB_READ_BYPASS_EN
    if (!m_stop && W_status == 2'd0) begin
      if (W_dstm == a) return W_valm;
      if (W_dste == a) return W_vale;
    end
`endif
    return m_regs[a];
  endfunction

  function automatic void m_edge();
    if (m_stop) return;
    if (W_status == 2'd0) begin
      if (W_dste != 4'hF) m_regs[W_dste] = W_vale;
      if (W_dstm != 4'hF) m_regs[W_dstm] = W_valm;
      if (W_icode != 4'd1) m_cnt = m_cnt + 1;
    end else begin
      m_stop = 1; m_lstat = W_status;
    end
  endfunction

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " rvala"}, d_rvala, m_rd(d_srca));
    chk({tag, " rvalb"}, d_rvalb, m_rd(d_srcb));
    chk({tag, " stat"}, 64'(stat), 64'(m_stop ? m_lstat : W_status));
    chk({tag, " halted"}, 64'(halted), 64'(m_stop));
    chk({tag, " count"}, 64'(retired_count), 64'(m_cnt));
  endtask

  task automatic drive(input logic [1:0] st, input logic [3:0] ic,
                       input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm,
                       input logic [3:0] sa, input logic [3:0] sb);
    W_status = st; W_icode = ic; W_dste = de; W_vale = ve;
    W_dstm = dm; W_valm = vm; d_srca = sa; d_srcb = sb;
  endtask

  task automatic tick();
    @(posedge clock);
    m_edge();
    #1;
  endtask

  typedef struct {
    logic [1:0]  st;
    logic [3:0]  ic, de, dm;
    logic [63:0] ve, vm;
    logic [3:0]  sa, sb;
    logic [63:0] ea, eb;
    logic [1:0]  es;
    logic        eh;
    logic [31:0] ec;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [63:0] old5;
    logic [31:0] cnt_hold;

    tbl[0] = '{2'd0, 4'd6, 4'd3, 4'hF, 64'h11, 64'h99,
               4'd3, 4'hF, 64'h11, 64'h0, 2'd0, 1'b0, 32'd1};
    tbl[1] = '{2'd0, 4'd2, 4'd4, 4'd4, 64'h100, 64'h200,
               4'd4, 4'd3, 64'h200, 64'h11, 2'd0, 1'b0, 32'd2};
    for (int i = 2; i < 7; i++)
      tbl[i] = '{2'd0, 4'd1, 4'hF, 4'hF, 64'hDEAD, 64'hBEEF,
                 4'd4, 4'd3, 64'h200, 64'h11, 2'd0, 1'b0, 32'd2};

    reset = 1'b1;
    drive(2'd0, 4'd1, 4'hF, 64'd0, 4'hF, 64'd0, 4'd3, 4'd4);
    m_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset rvala", d_rvala, 64'd0);
    chk("reset rvalb", d_rvalb, 64'd0);
    chk("reset stat", 64'(stat), 64'd0);
    chk("reset halted", 64'(halted), 64'd0);
    chk("reset count", 64'(retired_count), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].st, tbl[i].ic, tbl[i].de, tbl[i].ve,
            tbl[i].dm, tbl[i].vm, tbl[i].sa, tbl[i].sb);
      tick();
      chk($sformatf("vec%0d rvala", i), d_rvala, tbl[i].ea);
      chk($sformatf("vec%0d rvalb", i), d_rvalb, tbl[i].eb);
      chk($sformatf("vec%0d stat", i), 64'(stat), 64'(tbl[i].es));
      chk($sformatf("vec%0d halted", i), 64'(halted), 64'(tbl[i].eh));
      chk($sformatf("vec%0d count", i), 64'(retired_count),
          64'(tbl[i].ec));
    end

    // same-cycle read of a register being written
    drive(2'd0, 4'd3, 4'd7, 64'h55, 4'hF, 64'd0, 4'd7, 4'hF);
    #1;
`ifdef WB_READ_BYPASS_EN
    chk("same-cycle read", d_rvala, 64'h55);
`else
    chk("same-cycle read", d_rvala, 64'h0);
`endif
    tick();
    chk("reg7 after commit", d_rvala, 64'h55);

    // random AOK traffic against the model
    for (int n = 0; n < 300; n++) begin
      drive(2'd0, 4'($urandom_range(1, 11)),
            4'($urandom_range(0, 15)), {$urandom, $urandom},
            4'($urandom_range(0, 15)), {$urandom, $urandom},
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      #1;
      chk_model("rand pre");
      tick();
      chk_model("rand post");
    end

    // address fault: no commit, status latched, later writes ignored
    old5 = m_regs[5];
    cnt_hold = m_cnt;
    drive(2'd2, 4'd5, 4'd5, 64'hAA, 4'hF, 64'd0, 4'd5, 4'hF);
    #1;
    chk("adr pre stat", 64'(stat), 64'd2);
    chk("adr pre halted", 64'(halted), 64'd0);
    tick();
    chk("adr reg5", d_rvala, old5);
    chk("adr stat", 64'(stat), 64'd2);
    chk("adr halted", 64'(halted), 64'd1);
    drive(2'd0, 4'd3, 4'd5, 64'hBB, 4'hF, 64'd0, 4'd5, 4'hF);
    repeat (3) tick();
    chk("stopped reg5", d_rvala, old5);
    chk("stopped stat", 64'(stat), 64'd2);
    chk("stopped count", 64'(retired_count), 64'(cnt_hold));
    chk_model("stopped");

    // asynchronous reset pulse between clock edges
    drive(2'd0, 4'd1, 4'hF, 64'd0, 4'hF, 64'd0, 4'd0, 4'd1);
    #2;
    reset = 1'b1;
    m_reset();
    #1;
    chk("async stat", 64'(stat), 64'd0);
    chk("async halted", 64'(halted), 64'd0);
    chk("async count", 64'(retired_count), 64'd0);
    for (int r = 0; r < 15; r++) begin
      d_srca = 4'(r);
      #0.1;
      chk($sformatf("async reg%0d", r), d_rvala, 64'd0);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;

    // halt retires: status HLT, not counted, no commit
    drive(2'd0, 4'd3, 4'd2, 64'h77, 4'hF, 64'd0, 4'd2, 4'd1);
    tick();
    chk("pre-halt reg2", d_rvala, 64'h77);
    drive(2'd1, 4'd0, 4'd1, 64'h66, 4'hF, 64'd0, 4'd2, 4'd1);
    #1;
    chk("halt pre stat", 64'(stat), 64'd1);
    tick();
    chk("halt stat", 64'(stat), 64'd1);
    chk("halt halted", 64'(halted), 64'd1);
    chk("halt count", 64'(retired_count), 64'd1);
    chk("halt reg1", d_rvalb, 64'd0);
    drive(2'd3, 4'd3, 4'hF, 64'd0, 4'hF, 64'd0, 4'd2, 4'd1);
    tick();
    chk("halt held stat", 64'(stat), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
